// File: rtl/switch_egress_port.sv
// rtl/switch_egress_port.sv - egress side of the switch: round-robin collect, screen, buffer, transmit
module switch_egress_port #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_ID    = 0,
  parameter int PKT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*PKT_WIDTH-1:0]  in_pkt,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic                            out_valid,
  output logic [PKT_WIDTH-1:0]            out_pkt,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [15:0]                     tx_count,
  output logic [15:0]                     drop_count,
  output logic                            drop_pulse
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PKT_WIDTH-1:0] last_q, last_d;
  logic [15:0]          tx_q, tx_d, drop_q, drop_d;
  logic                 drop_pulse_q, drop_pulse_d;
  logic [PKT_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                 full, grant_valid, legal, push, pop;
  logic [PW-1:0]        grant_idx;
  int                   idx;
  logic [PKT_WIDTH-1:0] grant_pkt, head;
  logic [3:0]           src, tgt, lane_oh;

  // Scan from rr_ptr with wrap; grants are suppressed while full and during reset.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    full        = (count_q == CW'(FIFO_DEPTH));
    if (!full && !rst) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
        if (!grant_valid && in_valid[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = PW'(idx);
        end
      end
    end
    in_ready = grant_valid ? (NUM_PORTS'(1) << grant_idx) : '0;
  end

  // A packet is legal only if its source is exactly its own lane, it has a target,
  // it does not loop back to its source (except broadcast), and it is meant for us.
  always_comb begin
    grant_pkt = in_pkt[int'(grant_idx)*PKT_WIDTH +: PKT_WIDTH];
    src       = grant_pkt[PKT_WIDTH-1 -: 4];
    tgt       = grant_pkt[PKT_WIDTH-5 -: 4];
    lane_oh   = 4'b0001 << grant_idx;
    legal     = (src == lane_oh) && (tgt != 4'h0) &&
                ((tgt == 4'hF) || ((src & tgt) == 4'h0)) &&
                tgt[PORT_ID] && !src[PORT_ID];
    push      = grant_valid && legal;
    pop       = (count_q != '0) && out_ready;
    head      = mem_q[rd_ptr_q];
  end

  always_comb begin
    rr_ptr_d     = grant_valid ? PW'((int'(grant_idx) + 1) % NUM_PORTS) : rr_ptr_q;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    last_d       = pop ? head : last_q;
    tx_d         = (pop && tx_q != 16'hFFFF) ? tx_q + 16'd1 : tx_q;
    drop_pulse_d = grant_valid && !legal;
    drop_d       = (drop_pulse_d && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_q       <= '0;
      tx_q         <= '0;
      drop_q       <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_q       <= last_d;
      tx_q         <= tx_d;
      drop_q       <= drop_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= grant_pkt;
  end

  // While empty the output holds the last packet that left the head.
  assign out_valid  = (count_q != '0);
  assign out_pkt    = out_valid ? head : last_q;
  assign fifo_count = count_q;
  assign tx_count   = tx_q;
  assign drop_count = drop_q;
  assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_switch_egress_port.sv
// tb/tb_switch_egress_port.sv - directed self-checking bench for switch_egress_port (PORT_ID=0)
module tb_switch_egress_port;

  logic        clk, rst;
  logic [3:0]  in_valid;
  logic [63:0] in_pkt;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_pkt;
  logic        out_ready;
  logic [4:0]  fifo_count;
  logic [15:0] tx_count, drop_count;
  logic        drop_pulse;

  int checks = 0;
  int errors = 0;

  switch_egress_port #(.NUM_PORTS(4), .PORT_ID(0), .PKT_WIDTH(16), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pkt(in_pkt), .in_ready(in_ready),
    .out_valid(out_valid), .out_pkt(out_pkt), .out_ready(out_ready),
    .fifo_count(fifo_count), .tx_count(tx_count), .drop_count(drop_count),
    .drop_pulse(drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [15:0] pkt);
    in_pkt[lane*16 +: 16] = pkt;
  endtask

  task automatic apply_reset();
    in_valid  = 4'h0;
    in_pkt    = '0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 4'hF;
    in_pkt   = {16'h8100, 16'h4100, 16'h2100, 16'h0000};
    #1;
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL rst_in_ready got %h exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_pkt !== 16'h0) begin errors++; $display("FAIL rst_out_pkt got %h exp 0", out_pkt); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    checks++; if (tx_count !== 16'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", tx_count, drop_count); end
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL rst_drop_pulse got %b exp 0", drop_pulse); end
    in_valid = 4'h0;
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_lane(1, 16'h21A5);
    in_valid = 4'b0010;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL single_grant got %b exp 0010", in_ready); end
    tick();
    in_valid = 4'h0;
    checks++; if (out_valid !== 1'b1 || out_pkt !== 16'h21A5) begin errors++; $display("FAIL single_out got %b/%h exp 1/21a5", out_valid, out_pkt); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (tx_count !== 16'd1 || fifo_count !== 5'd0) begin errors++; $display("FAIL single_tx got %0d/%0d exp 1/0", tx_count, fifo_count); end
    checks++; if (out_valid !== 1'b0 || out_pkt !== 16'h21A5) begin errors++; $display("FAIL single_hold got %b/%h exp 0/21a5", out_valid, out_pkt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [6];
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    apply_reset();
    set_lane(1, 16'h2111);
    set_lane(2, 16'h4112);
    set_lane(3, 16'h8113);
    in_valid  = 4'b1110;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (in_ready !== exp_g[k]) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", k, in_ready, exp_g[k]); end
      if (k > 0) begin
        checks++; if (out_valid !== 1'b1 || out_pkt[15:12] !== exp_g[k-1]) begin errors++; $display("FAIL rr_order[%0d] got %b/%h exp 1/%h", k, out_valid, out_pkt[15:12], exp_g[k-1]); end
      end
      tick();
    end
    in_valid = 4'h0;
    checks++; if (out_pkt[15:12] !== 4'b1000) begin errors++; $display("FAIL rr_last got %h exp 8", out_pkt[15:12]); end
    tick();
    out_ready = 1'b0;
    checks++; if (fifo_count !== 5'd0 || tx_count !== 16'd6) begin errors++; $display("FAIL rr_done got %0d/%0d exp 0/6", fifo_count, tx_count); end
  endtask

  task automatic test_drop();
    int          lanes [5];
    logic [15:0] pkts [5];
    lanes = '{0, 1, 1, 1, 3};
    pkts  = '{16'h1100, 16'h3100, 16'h2000, 16'h2400, 16'h2100};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      in_pkt   = '0;
      set_lane(lanes[k], pkts[k]);
      in_valid = 4'b0001 << lanes[k];
      #1;
      checks++; if (in_ready !== (4'b0001 << lanes[k])) begin errors++; $display("FAIL drop_consume[%0d] got %b exp %b", k, in_ready, 4'b0001 << lanes[k]); end
      tick();
      checks++; if (drop_pulse !== 1'b1 || drop_count !== 16'(k + 1)) begin errors++; $display("FAIL drop_pulse[%0d] got %b/%0d exp 1/%0d", k, drop_pulse, drop_count, k + 1); end
    end
    in_valid = 4'h0;
    tick();
    checks++; if (drop_pulse !== 1'b0 || drop_count !== 16'd5) begin errors++; $display("FAIL drop_total got %b/%0d exp 0/5", drop_pulse, drop_count); end
    checks++; if (fifo_count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drop_empty got %0d/%b exp 0/0", fifo_count, out_valid); end
    set_lane(1, 16'h2F11);
    in_valid = 4'b0010;
    tick();
    in_valid = 4'h0;
    checks++; if (fifo_count !== 5'd1 || out_pkt !== 16'h2F11) begin errors++; $display("FAIL bcast_fwd got %0d/%h exp 1/2f11", fifo_count, out_pkt); end
    checks++; if (drop_pulse !== 1'b0 || drop_count !== 16'd5) begin errors++; $display("FAIL bcast_nodrop got %b/%0d exp 0/5", drop_pulse, drop_count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    apply_reset();
    in_valid = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      set_lane(1, {8'h21, 8'(k)});
      tick();
    end
    set_lane(1, 16'h2110);
    #1;
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", fifo_count); end
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL full_block got %b exp 0000", in_ready); end
    tick();
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL full_no_passthru got %b exp 0000", in_ready); end
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (fifo_count !== 5'd15 || in_ready !== 4'b0010) begin errors++; $display("FAIL full_resume got %0d/%b exp 15/0010", fifo_count, in_ready); end
    tick();
    in_valid  = 4'h0;
    out_ready = 1'b1;
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_refill got %0d exp 16", fifo_count); end
    for (int k = 1; k <= 16; k++) begin
      checks++; if (out_pkt !== {8'h21, 8'(k)}) begin errors++; $display("FAIL drain[%0d] got %h exp %h", k, out_pkt, {8'h21, 8'(k)}); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (fifo_count !== 5'd0 || tx_count !== 16'd17) begin errors++; $display("FAIL drain_done got %0d/%0d exp 0/17", fifo_count, tx_count); end
  endtask

  task automatic test_push_pop();
    apply_reset();
    in_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      set_lane(1, {8'h21, 8'(8'h50 + k)});
      tick();
    end
    set_lane(1, 16'h2155);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010 || fifo_count !== 5'd5) begin errors++; $display("FAIL pp_pre got %b/%0d exp 0010/5", in_ready, fifo_count); end
    tick();
    in_valid  = 4'h0;
    out_ready = 1'b0;
    checks++; if (fifo_count !== 5'd5 || out_pkt !== 16'h2151) begin errors++; $display("FAIL pp_count got %0d/%h exp 5/2151", fifo_count, out_pkt); end
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      checks++; if (out_pkt !== {8'h21, 8'(8'h50 + k)}) begin errors++; $display("FAIL pp_order[%0d] got %h exp %h", k, out_pkt, {8'h21, 8'(8'h50 + k)}); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_lane(1, 16'h2400);
    in_valid = 4'b0010;
    tick();
    in_valid = 4'b0100;
    for (int k = 0; k < 7; k++) begin
      set_lane(2, {8'h41, 8'(8'h70 + k)});
      tick();
    end
    in_valid = 4'h0;
    checks++; if (fifo_count !== 5'd7 || drop_count !== 16'd1) begin errors++; $display("FAIL mid_pre got %0d/%0d exp 7/1", fifo_count, drop_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin errors++; $display("FAIL mid_async got %b/%0d exp 0/0", out_valid, fifo_count); end
    checks++; if (drop_count !== 16'd0 || tx_count !== 16'd0 || out_pkt !== 16'h0) begin errors++; $display("FAIL mid_clear got %0d/%0d/%h exp 0/0/0", drop_count, tx_count, out_pkt); end
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    in_pkt   = {16'h8100, 16'h4100, 16'h2100, 16'h1100};
    in_valid = 4'hF;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr0 got %b exp 0001", in_ready); end
    tick();
    in_valid = 4'h0;
    checks++; if (drop_pulse !== 1'b1 || fifo_count !== 5'd0) begin errors++; $display("FAIL mid_post got %b/%0d exp 1/0", drop_pulse, fifo_count); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'h0;
    in_pkt    = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_full();
    test_push_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
